// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the ysyx_24080014 instruction fetch unit.
package ysyx_24080014_pkg;

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_RESP = 3'd2,
        S_OUT  = 3'd3,
        S_WAIT = 3'd4
    } ifu_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ACCESS   = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: owns the PC, issues one read per retired instruction
// and presents {inst, pc, err_cause} to decode.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            ar_valid,
    input  logic            ar_ready,
    output logic [XLEN-1:0] ar_addr,
    input  logic            r_valid,
    output logic            r_ready,
    input  logic [31:0]     r_data,
    input  logic [1:0]      r_resp,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      err_cause
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [1:0]      err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC[XLEN-1:0];
            inst_q  <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                if (ar_ready) state_d = S_RESP;
            end
            S_RESP: begin
                if (r_valid) begin
                    inst_d  = r_data;
                    err_d   = (r_resp != 2'b00) ? ERR_ACCESS : ERR_NONE;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (inst_ready) state_d = S_WAIT;
            end
            S_WAIT: ;
            default: state_d = S_BOOT;
        endcase

        // Both PC-load paths share the alignment check; a misaligned target
        // skips the bus and reports a NOP carrying the fault.
        if ((state_q == S_WAIT && npc_valid) ||
            (state_q == S_OUT && inst_ready && npc_valid)) begin
            pc_d = npc;
            if (npc[1:0] == 2'b00) begin
                state_d = S_REQ;
            end else begin
                state_d = S_OUT;
                inst_d  = NOP_INST;
                err_d   = ERR_MISALIGN;
            end
        end
    end

    assign ar_valid   = (state_q == S_REQ);
    assign r_ready    = (state_q == S_RESP);
    assign inst_valid = (state_q == S_OUT);
    assign ar_addr    = pc_q;
    assign inst_pc    = pc_q;
    assign inst       = inst_q;
    assign err_cause  = err_q;

    npc_only_when_retiring: assert property (
        @(posedge clk) disable iff (!rst_n)
        npc_valid |-> (state_q == S_WAIT || (state_q == S_OUT && inst_ready))
    );

endmodule

// File: doc/ysyx_24080014_ifu.md
Name: ysyx_24080014_ifu

Overview:
- Instruction fetch unit: owns the architectural PC register and fetches one instruction per retired instruction over a valid/ready read bus.
- Delivers {inst, pc} to the decode stage.
- Sits directly downstream of the next-PC logic. It consumes that stage's next_pc and npc_valid, and feeds the fetched instruction and PC back into the datapath.
- Exactly one fetch is outstanding at any time. There is no speculation.

Parameters:
- RESET_PC, 32'h8000_0000: PC loaded on reset.
- XLEN, 32: address and data width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- npc_valid  in  1  next_pc is valid; the current instruction retires this cycle
- npc  in  XLEN  next PC from the jump stage
- ar_valid  out  1  read-address request valid
- ar_ready  in  1  memory accepts the address
- ar_addr  out  XLEN  fetch address (equal to pc)
- r_valid  in  1  read data valid
- r_ready  out  1  IFU accepts read data
- r_data  in  32  instruction word
- r_resp  in  2  00 = OKAY; any other value = access fault
- inst_valid  out  1  instruction presented to decode
- inst_ready  in  1  decode accepts the instruction
- inst  out  32  fetched instruction
- inst_pc  out  XLEN  PC of inst
- err_cause  out  2  00 none, 01 access fault, 10 misaligned PC; qualified by inst_valid

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - pc = RESET_PC, state = S_BOOT, inst = 0, err_cause = 0.
  - ar_valid, r_ready and inst_valid are all 0.
  - Reset asserted mid-operation aborts any transaction immediately. A late r_valid from that transaction is ignored because r_ready = 0.
- Outputs are decoded from registered state only: ar_valid = (state == S_REQ), r_ready = (state == S_RESP), inst_valid = (state == S_OUT). ar_addr and inst_pc always equal pc.
- S_BOOT: go to S_REQ on the next clock. The first ar_valid therefore appears 1 cycle after rst_n deasserts.
- S_REQ:
  - ar_valid = 1 and ar_addr = pc, both held stable until ar_ready.
  - ar_valid & ar_ready: go to S_RESP.
  - r_valid seen while in S_REQ is ignored.
- S_RESP:
  - r_ready = 1.
  - On r_valid: latch inst = r_data and err_cause = (r_resp != 0) ? 01 : 00, then go to S_OUT.
  - No timeout; the IFU waits indefinitely.
- S_OUT:
  - inst_valid = 1. inst, inst_pc and err_cause are held stable until inst_ready.
  - inst_valid & inst_ready & !npc_valid: go to S_WAIT.
  - inst_valid & inst_ready & npc_valid in the same cycle: load pc = npc and go straight to the PC check (see Redirect). This is the single-cycle-core fast path.
- S_WAIT:
  - All handshake outputs are 0.
  - On npc_valid: load pc = npc and go to the PC check.
- Redirect / PC check (applies to both load paths):
  - npc[1:0] == 00: next state S_REQ.
  - Otherwise: next state S_OUT with inst = 32'h0000_0013, err_cause = 10, and no bus request issued.
- npc_valid in S_BOOT, S_REQ, S_RESP, or in S_OUT without inst_ready: protocol violation. It is ignored, pc is unchanged, and a simulation-only assertion fires.
- Latency:
  - Minimum PC-load-to-inst_valid with zero-wait memory (ar_ready = 1, r_valid in the cycle after the AR handshake) is 3 cycles: S_REQ, S_RESP, S_OUT.
  - Throughput is therefore at most one instruction per 3 cycles.
- Arithmetic: the IFU performs no PC increment; it always uses npc verbatim. pc is XLEN bits and wraps naturally.

Decomposition:
- Shared package ysyx_24080014_pkg holds:
  - state enum {S_BOOT, S_REQ, S_RESP, S_OUT, S_WAIT}
  - err_cause constants ERR_NONE / ERR_ACCESS / ERR_MISALIGN
  - the RESET_PC default and the NOP encoding 32'h0000_0013
- No sub-module: the FSM, PC register and output latch live in one module.

Test Plan:
- Reset then release, memory ar_ready = 1, r_valid 1 cycle later with r_data = 32'h0000_0297 -> ar_addr = 32'h8000_0000 on cycle 1; inst_valid on cycle 3 with inst = 32'h0000_0297, inst_pc = 32'h8000_0000, err_cause = 00.
- ar_ready held low 4 cycles, then high -> ar_valid stays 1 and ar_addr is unchanged throughout; exactly one AR handshake occurs.
- inst_ready and npc_valid both high in the same cycle with npc = 32'h8000_0010 -> the next cycle is S_REQ with ar_addr = 32'h8000_0010; S_WAIT is never entered.
- npc = 32'h8000_0006 delivered in S_WAIT -> no ar_valid; the next cycle shows inst_valid = 1, inst = 32'h0000_0013, err_cause = 10, inst_pc = 32'h8000_0006.
- r_resp = 2'b10 with r_data = 32'hDEAD_BEEF -> inst_valid with err_cause = 01 and inst = 32'hDEAD_BEEF.
- rst_n asserted while in S_RESP, then r_valid pulses during reset -> outputs go to 0 immediately; after release the first fetch is from 32'h8000_0000 and the stale data is never presented.
